branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and branch-resolution stage for the single-cycle RV32I core. Sits directly downstream of the branch comparator. It drives the comparator's signed/unsigned select from `funct3`, consumes the `less`/`equal` flags, resolves conditional branches, `JAL` and `JALR`, and registers the next PC. It also redirects misaligned control-flow targets to a trap vector with a one-cycle instruction kill, and keeps retired-branch and taken-branch counters.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `TRAP_VEC`, default `32'h0000_0100`: PC loaded on a misaligned-target trap.
- `CNT_W`, default `32`: width of the performance counters.

Ports (clock and reset first):
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  hold all state this cycle.
- `i_instr_valid`  in  1  current instruction is real; 0 = bubble.
- `i_is_branch`  in  1  conditional branch.
- `i_is_jal`  in  1  `JAL`.
- `i_is_jalr`  in  1  `JALR`.
- `i_funct3`  in  3  branch type.
- `i_br_less`  in  1  comparator less-than flag.
- `i_br_equal`  in  1  comparator equal flag.
- `i_rs1_data`  in  32  `JALR` base.
- `i_imm`  in  32  sign-extended immediate.
- `o_br_un`  out  1  to comparator: 1 = signed compare, 0 = unsigned.
- `o_pc`  out  32  current PC (registered).
- `o_pc_four`  out  32  `o_pc + 4`, the link value.
- `o_taken`  out  1  control transfer taken this cycle (combinational).
- `o_kill`  out  1  current instruction must not write back (FLUSH state).
- `o_misalign`  out  1  one-cycle pulse, registered, on trap entry.
- `o_bad_addr`  out  32  last misaligned target captured.
- `o_branch_cnt`  out  `CNT_W`  retired conditional branches.
- `o_taken_cnt`  out  `CNT_W`  taken conditional branches.

## Operation
- **Comparator select:** `o_br_un = ~i_funct3[1]`, purely combinational.
- **Branch condition by `funct3`:**
  - `000` BEQ: taken when `equal`.
  - `001` BNE: taken when `!equal`.
  - `100` BLT: taken when `less`.
  - `101` BGE: taken when `!less`.
  - `110` BLTU: taken when `less`.
  - `111` BGEU: taken when `!less`.
  - `010` and `011`: never taken.
- **Type priority** when several flags are set: `JALR` > `JAL` > branch.
- **Targets:**
  - Branch and `JAL`: `o_pc + i_imm`, modulo 2^32.
  - `JALR`: `(i_rs1_data + i_imm) & ~32'h1`.
- **Taken:** `o_taken = i_instr_valid & state==RUN & (jal | jalr | branch condition)`.
- **Misaligned:** `o_taken & target[1]`. There is no compressed-instruction support.
- **FSM, 2 states:**
  - RUN → FLUSH on a misaligned target when `!i_stall`. On that edge: PC ← `TRAP_VEC`, `o_bad_addr` ← target, `o_misalign` ← 1.
  - FLUSH → RUN on the next non-stalled edge. PC holds in FLUSH. `o_kill = 1` for the whole FLUSH state, so the instruction fetched at `TRAP_VEC` is not yet executed. `o_taken = 0` in FLUSH.
  - FLUSH with `i_stall`: stays in FLUSH.
- **Next PC in RUN, in priority order:**
  1. `i_stall`: hold.
  2. Misaligned: `TRAP_VEC`.
  3. Taken: target.
  4. `i_instr_valid`: `o_pc + 4`.
  5. Otherwise: hold.
- **Counters** advance only on non-stalled edges in RUN with `i_instr_valid & i_is_branch & !i_is_jal & !i_is_jalr`:
  - `o_branch_cnt` += 1.
  - `o_taken_cnt` += 1 if taken and not misaligned.
  - A misaligned branch counts as retired, not as taken.
  - Both wrap modulo 2^`CNT_W`.

## Timing
- **Reset (asynchronous, immediate):** `o_pc = RESET_PC`, state = RUN, `o_misalign = 0`, `o_bad_addr = 0`, both counters = 0, `o_kill = 0`.
- **Combinational, same cycle:** `o_br_un`, `o_taken`, `o_pc_four` and target are all valid in the same cycle as the inputs. The comparator flags arrive combinationally within the cycle.
- **PC latency:** one edge. The new PC appears after the rising edge that samples a non-stalled instruction.
- **`o_misalign`:** high exactly the one cycle following the trap edge. It deasserts on the next edge even if `i_stall` is asserted.
- **Stall:** freezes PC, FSM, counters and `o_bad_addr`. Combinational outputs still reflect the inputs.
- **Reset mid-FLUSH:** returns to RUN at `RESET_PC`; `o_kill` drops immediately.
- **PC wrap:** `o_pc = 32'hFFFF_FFFC` with a not-taken instruction gives a next PC of `0`.

## Test plan
- **Reset:** assert `i_rst_n = 0` mid-cycle. All outputs go to reset values immediately. Then 3 valid non-branch cycles give `o_pc` = `0x0`, `0x4`, `0x8`, `0xC`.
- **BEQ and BNE:** `o_pc = 0x20`, BEQ (`funct3 = 000`), `i_imm = 0x40`, `equal = 1`. Required: `o_taken = 1`, next PC `0x60`, `o_branch_cnt = 1`, `o_taken_cnt = 1`. Then BNE with `equal = 1`: next PC `0x64`.
- **Signed/unsigned select:** `funct3 = 110` gives `o_br_un = 0`; `funct3 = 100` gives `o_br_un = 1`. BGEU with `less = 0` at PC `0x10`, `imm = -8`: next PC `0x8`.
- **JALR:** `rs1 = 0x1001`, `imm = 0x4`. Required: target `0x1004` (bit 0 cleared), `o_pc_four = PC + 4`, counters unchanged.
- **Misaligned trap:** JAL at `0x0` with `imm = 0x6`. Required: next PC `0x100`, `o_bad_addr = 0x6`, `o_misalign` high for 1 cycle. `o_kill = 1` for one cycle with PC held at `0x100`; the following valid cycle goes to `0x104`.
- **Stall and counter wrap:** with `CNT_W = 2` and 4 taken branches, both counters wrap to 0. Asserting `i_stall` during a taken branch leaves PC, counters and state unchanged.

Source files
------------

// File: rtl/branch_pc_if.sv
// Bus between the decode/compare side and the PC unit: decoded control flow in,
// PC, link value, trap status and branch counters out.
interface branch_pc_if #(
  parameter int CNT_W = 32
);
  logic             i_stall;
  logic             i_instr_valid;
  logic             i_is_branch;
  logic             i_is_jal;
  logic             i_is_jalr;
  logic [2:0]       i_funct3;
  logic             i_br_less;
  logic             i_br_equal;
  logic [31:0]      i_rs1_data;
  logic [31:0]      i_imm;
  logic             o_br_un;
  logic [31:0]      o_pc;
  logic [31:0]      o_pc_four;
  logic             o_taken;
  logic             o_kill;
  logic             o_misalign;
  logic [31:0]      o_bad_addr;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_taken_cnt;

  modport master (
    output i_stall, i_instr_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
           i_br_less, i_br_equal, i_rs1_data, i_imm,
    input  o_br_un, o_pc, o_pc_four, o_taken, o_kill, o_misalign, o_bad_addr,
           o_branch_cnt, o_taken_cnt
  );

  modport slave (
    input  i_stall, i_instr_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
           i_br_less, i_br_equal, i_rs1_data, i_imm,
    output o_br_un, o_pc, o_pc_four, o_taken, o_kill, o_misalign, o_bad_addr,
           o_branch_cnt, o_taken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// PC register and branch resolution for the single-cycle RV32I core, with
// misaligned-target trap (one-cycle kill) and retired/taken branch counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input logic        i_clk,
  input logic        i_rst_n,
  branch_pc_if.slave bus
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_bad_addr;
  logic             r_misalign;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic        w_run;
  logic        w_cond;
  logic        w_taken;
  logic        w_misalign;
  logic        w_retire;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;

  always_comb begin
    w_cond = 1'b0;
    case (bus.i_funct3)
      3'b000:  w_cond = bus.i_br_equal;
      3'b001:  w_cond = ~bus.i_br_equal;
      3'b100:  w_cond = bus.i_br_less;
      3'b101:  w_cond = ~bus.i_br_less;
      3'b110:  w_cond = bus.i_br_less;
      3'b111:  w_cond = ~bus.i_br_less;
      default: w_cond = 1'b0;
    endcase
  end

  // JALR clears bit 0 of its target; bit 1 is left alone so it can still trap.
  assign w_jalr_sum = bus.i_rs1_data + bus.i_imm;
  assign w_target   = bus.i_is_jalr ? {w_jalr_sum[31:1], 1'b0} : r_pc + bus.i_imm;

  assign w_run      = (r_state == ST_RUN);
  assign w_taken    = bus.i_instr_valid & w_run &
                      (bus.i_is_jalr | bus.i_is_jal | (bus.i_is_branch & w_cond));
  assign w_misalign = w_taken & w_target[1];
  assign w_retire   = w_run & ~bus.i_stall & bus.i_instr_valid & bus.i_is_branch &
                      ~bus.i_is_jal & ~bus.i_is_jalr;

  assign bus.o_br_un      = ~bus.i_funct3[1];
  assign bus.o_pc         = r_pc;
  assign bus.o_pc_four    = r_pc + 32'd4;
  assign bus.o_taken      = w_taken;
  assign bus.o_kill       = (r_state == ST_FLUSH);
  assign bus.o_misalign   = r_misalign;
  assign bus.o_bad_addr   = r_bad_addr;
  assign bus.o_branch_cnt = r_branch_cnt;
  assign bus.o_taken_cnt  = r_taken_cnt;

  // The misalign pulse clears on every edge, stall or not, so it lasts one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_bad_addr   <= 32'h0;
      r_misalign   <= 1'b0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (!bus.i_stall) begin
        case (r_state)
          ST_RUN: begin
            if (w_misalign) begin
              r_pc       <= TRAP_VEC;
              r_bad_addr <= w_target;
              r_misalign <= 1'b1;
              r_state    <= ST_FLUSH;
            end else if (w_taken) begin
              r_pc <= w_target;
            end else if (bus.i_instr_valid) begin
              r_pc <= r_pc + 32'd4;
            end
          end
          ST_FLUSH: r_state <= ST_RUN;
          default:  r_state <= ST_RUN;
        endcase
      end
      if (w_retire) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        if (w_taken && !w_misalign) begin
          r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios followed by random
// instruction streams, all compared against a behavioural PC/branch model.
module tb_branch_pc_unit;

  localparam int          CNT_W    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic i_clk;
  logic i_rst_n;

  branch_pc_if #(.CNT_W(CNT_W)) bus ();

  branch_pc_unit #(
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  logic [31:0] mPc;
  logic [31:0] mBad;
  bit          mFlush;
  bit          mMis;
  int unsigned mBr;
  int unsigned mTk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit condHolds(input logic [2:0] f3, input bit less, input bit eq);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] cntExp(input int unsigned n);
    return 32'(n % (32'd1 << CNT_W));
  endfunction

  task automatic checkRegistered();
    checkOutput("pc",        bus.o_pc,                mPc);
    checkOutput("misalign",  32'(bus.o_misalign),     32'(mMis));
    checkOutput("bad_addr",  bus.o_bad_addr,          mBad);
    checkOutput("kill",      32'(bus.o_kill),         32'(mFlush));
    checkOutput("branch_cnt", 32'(bus.o_branch_cnt),  cntExp(mBr));
    checkOutput("taken_cnt",  32'(bus.o_taken_cnt),   cntExp(mTk));
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mBad = 32'h0; mFlush = 1'b0; mMis = 1'b0; mBr = 0; mTk = 0;
  endtask

  // Reset is asserted mid-cycle and must take effect without a clock edge.
  task automatic doReset();
    #3;
    i_rst_n = 1'b0;
    #1;
    modelReset();
    checkRegistered();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Drives one instruction, checks everything mid-cycle, advances the model
  // over the rising edge, and returns 1 time unit after that edge.
  task automatic applyStimulus(input bit stall, input bit valid, input bit br, input bit jal,
                               input bit jalr, input logic [2:0] f3, input bit less,
                               input bit eq, input logic [31:0] rs1, input logic [31:0] imm);
    bit          tk;
    bit          mis;
    logic [31:0] tgt;
    bus.i_stall = stall; bus.i_instr_valid = valid; bus.i_is_branch = br;
    bus.i_is_jal = jal; bus.i_is_jalr = jalr; bus.i_funct3 = f3;
    bus.i_br_less = less; bus.i_br_equal = eq; bus.i_rs1_data = rs1; bus.i_imm = imm;

    tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (mPc + imm);
    tk  = valid && !mFlush && (jalr || jal || (br && condHolds(f3, less, eq)));
    mis = tk && tgt[1];

    @(negedge i_clk);
    checkRegistered();
    checkOutput("br_un",   32'(bus.o_br_un),   32'(f3 != 3'd6 && f3 != 3'd7 && f3 != 3'd2 && f3 != 3'd3));
    checkOutput("taken",   32'(bus.o_taken),   32'(tk));
    checkOutput("pc_four", bus.o_pc_four,      mPc + 32'd4);

    mMis = 1'b0;
    if (!stall) begin
      if (mFlush) begin
        mFlush = 1'b0;
      end else begin
        if (valid && br && !jal && !jalr) begin
          mBr++;
          if (tk && !mis) mTk++;
        end
        if (mis) begin
          mPc = TRAP_VEC; mBad = tgt; mMis = 1'b1; mFlush = 1'b1;
        end else if (tk) begin
          mPc = tgt;
        end else if (valid) begin
          mPc = mPc + 32'd4;
        end
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(0, 1, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rs1;
    logic [31:0] imm;
    int          kind;

    i_rst_n = 1'b1;
    bus.i_stall = 0; bus.i_instr_valid = 0; bus.i_is_branch = 0; bus.i_is_jal = 0;
    bus.i_is_jalr = 0; bus.i_funct3 = 3'd0; bus.i_br_less = 0; bus.i_br_equal = 0;
    bus.i_rs1_data = 32'h0; bus.i_imm = 32'h0;
    modelReset();
    @(posedge i_clk);
    #1;
    doReset();

    for (int i = 0; i < 3; i++) begin
      nop();
      checkOutput("seq_pc", bus.o_pc, 32'(4 * (i + 1)));
    end
    for (int i = 0; i < 5; i++) nop();
    checkOutput("pc_at_20", bus.o_pc, 32'h20);

    applyStimulus(0, 1, 1, 0, 0, 3'b000, 0, 1, 32'h0, 32'h40);
    checkOutput("beq_pc", bus.o_pc, 32'h60);
    checkOutput("beq_brcnt", 32'(bus.o_branch_cnt), 32'd1);
    checkOutput("beq_tkcnt", 32'(bus.o_taken_cnt), 32'd1);
    applyStimulus(0, 1, 1, 0, 0, 3'b001, 0, 1, 32'h0, 32'h40);
    checkOutput("bne_pc", bus.o_pc, 32'h64);

    applyStimulus(0, 0, 0, 0, 0, 3'b110, 0, 0, 32'h0, 32'h0);
    checkOutput("brun_bltu", 32'(bus.o_br_un), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 3'b100, 0, 0, 32'h0, 32'h0);
    checkOutput("brun_blt", 32'(bus.o_br_un), 32'd1);
    checkOutput("bubble_pc", bus.o_pc, 32'h64);

    applyStimulus(0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h0, -32'sd84);
    checkOutput("jal_pc", bus.o_pc, 32'h10);
    applyStimulus(0, 1, 1, 0, 0, 3'b111, 0, 0, 32'h0, -32'sd8);
    checkOutput("bgeu_pc", bus.o_pc, 32'h8);

    applyStimulus(0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h1001, 32'h4);
    checkOutput("jalr_pc", bus.o_pc, 32'h1004);
    checkOutput("jalr_link", bus.o_pc_four, 32'h1008);
    checkOutput("jalr_brcnt", 32'(bus.o_branch_cnt), 32'd3);
    checkOutput("jalr_tkcnt", 32'(bus.o_taken_cnt), 32'd2);

    applyStimulus(0, 1, 0, 0, 1, 3'b000, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h0, 32'h6);
    checkOutput("trap_pc", bus.o_pc, 32'h100);
    checkOutput("trap_bad", bus.o_bad_addr, 32'h6);
    checkOutput("trap_pulse", 32'(bus.o_misalign), 32'd1);
    checkOutput("trap_kill", 32'(bus.o_kill), 32'd1);
    nop();
    checkOutput("flush_pc", bus.o_pc, 32'h100);
    checkOutput("flush_pulse", 32'(bus.o_misalign), 32'd0);
    nop();
    checkOutput("post_flush_pc", bus.o_pc, 32'h104);

    applyStimulus(0, 1, 0, 0, 1, 3'b000, 0, 0, 32'hFFFF_FFFC, 32'h0);
    nop();
    checkOutput("pc_wrap", bus.o_pc, 32'h0);

    applyStimulus(0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h0, 32'h2);
    doReset();

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0, 3'b000, 0, 1, 32'h0, 32'h8);
    checkOutput("wrap_brcnt", 32'(bus.o_branch_cnt), 32'd0);
    checkOutput("wrap_tkcnt", 32'(bus.o_taken_cnt), 32'd0);
    applyStimulus(1, 1, 1, 0, 0, 3'b000, 0, 1, 32'h0, 32'h8);
    checkOutput("stall_pc", bus.o_pc, 32'h20);
    checkOutput("stall_taken", 32'(bus.o_taken), 32'd1);

    applyStimulus(0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h0, 32'h2);
    applyStimulus(1, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
    checkOutput("stall_flush_kill", 32'(bus.o_kill), 32'd1);
    nop();

    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 9));
      imm  = 32'(int'($urandom_range(0, 255)) - 128) << 2;
      if ($urandom_range(0, 9) == 0) imm = imm + 32'h2;
      rs1  = $urandom;
      if ($urandom_range(0, 1) == 0) rs1 = rs1 & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                    kind <= 3 || kind == 6, kind == 4 || (kind == 6 && $urandom_range(0, 1) == 1),
                    kind == 5 || (kind == 6 && $urandom_range(0, 1) == 1),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rs1, imm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
